// File: rtl/wb_register_file.sv
// Write-back register file: 2**ADDR_WIDTH registers, r0 hardwired to zero, two combinational read ports.
// Optional same-cycle write-through bypass on the read ports when REGFILE_WB_BYPASS_EN is defined.
module wb_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  WB_RegWrite,
    input  logic [DATA_WIDTH-1:0] WB_DATA,
    input  logic [ADDR_WIDTH-1:0] WB_RD,
    input  logic [ADDR_WIDTH-1:0] ID_RS,
    input  logic [ADDR_WIDTH-1:0] ID_RT,
    output logic [DATA_WIDTH-1:0] ID_RS_DATA,
    output logic [DATA_WIDTH-1:0] ID_RT_DATA
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] rs_data_s;
    logic [DATA_WIDTH-1:0] rt_data_s;

    assign wr_en_s = WB_RegWrite && (WB_RD != ZERO_IDX);

    // Next-state of the array: commit the write-back result, keep r0 pinned at zero.
    always_comb begin
        regs_d = regs_q;
        if (wr_en_s) begin
            regs_d[WB_RD] = WB_DATA;
        end else begin
            regs_d[WB_RD] = regs_q[WB_RD];
        end
        regs_d[0] = ZERO_DATA;
    end

    // Storage; asynchronous reset clears every register and blocks writes while high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= ZERO_DATA;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port A.
    always_comb begin
        if (ID_RS == ZERO_IDX) begin
            rs_data_s = ZERO_DATA;
`ifdef REGFILE_WB_BYPASS_EN
        end else if (wr_en_s && !reset && (ID_RS == WB_RD)) begin
            rs_data_s = WB_DATA;
`endif
        end else begin
            rs_data_s = regs_q[ID_RS];
        end
    end

    // Read port B, independent of port A.
    always_comb begin
        if (ID_RT == ZERO_IDX) begin
            rt_data_s = ZERO_DATA;
`ifdef REGFILE_WB_BYPASS_EN
        end else if (wr_en_s && !reset && (ID_RT == WB_RD)) begin
            rt_data_s = WB_DATA;
`endif
        end else begin
            rt_data_s = regs_q[ID_RT];
        end
    end

    assign ID_RS_DATA = rs_data_s;
    assign ID_RT_DATA = rt_data_s;

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file; expectations follow REGFILE_WB_BYPASS_EN when defined.
module tb_wb_register_file;

    logic        clock = 1'b0;
    logic        reset;
    logic        WB_RegWrite;
    logic [31:0] WB_DATA;
    logic [4:0]  WB_RD;
    logic [4:0]  ID_RS;
    logic [4:0]  ID_RT;
    logic [31:0] ID_RS_DATA;
    logic [31:0] ID_RT_DATA;

    int errors = 0;
    int checks = 0;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [31:0] model [32];
    logic [63:0] exp_q [$];
    logic [63:0] exp_v;

    wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .WB_RegWrite (WB_RegWrite),
        .WB_DATA     (WB_DATA),
        .WB_RD       (WB_RD),
        .ID_RS       (ID_RS),
        .ID_RT       (ID_RT),
        .ID_RS_DATA  (ID_RS_DATA),
        .ID_RT_DATA  (ID_RT_DATA)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference read: r0 is zero, bypass returns WB_DATA in the same cycle when enabled.
    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] rd, input logic [31:0] d,
                                             input logic rst);
        if (idx == 5'd0) return 32'h0;
        if (BYPASS && we && !rst && rd != 5'd0 && rd == idx) return d;
        return model[idx];
    endfunction

    task automatic do_write(input logic [4:0] rd, input logic [31:0] d);
        WB_RegWrite = 1'b1; WB_RD = rd; WB_DATA = d;
        tick();
        if (rd != 5'd0) model[rd] = d;
        WB_RegWrite = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic test_reset();
        ID_RS = 5'd5; ID_RT = 5'd31;
        tick(); tick();
        exp_q.push_back({32'h0, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks += 2;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL reset_hold_rs got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL reset_hold_rt got=%h exp=%h", ID_RT_DATA, exp_v[31:0]); end
        reset = 1'b0;
        clear_model();
        do_write(5'd5, 32'hDEADBEEF);
        exp_q.push_back({32'hDEADBEEF, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks += 2;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL r5_written got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL r31_untouched got=%h exp=%h", ID_RT_DATA, exp_v[31:0]); end
        // Asynchronous clear without a clock edge.
        #2 reset = 1'b1;
        clear_model();
        exp_q.push_back({32'h0, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL reset_async_rs got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        // A write presented while reset is high is lost and not bypassed.
        WB_RegWrite = 1'b1; WB_RD = 5'd5; WB_DATA = 32'h0BADF00D;
        exp_q.push_back({32'h0, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL reset_no_bypass got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        tick();
        WB_RegWrite = 1'b0;
        reset = 1'b0;
        exp_q.push_back({32'h0, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks += 2;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL reset_write_lost got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL reset_after_rt got=%h exp=%h", ID_RT_DATA, exp_v[31:0]); end
    endtask

    task automatic test_write_read();
        do_write(5'd7, 32'h12345678);
        ID_RS = 5'd7; ID_RT = 5'd7;
        exp_q.push_back({32'h12345678, 32'h12345678});
        #1;
        exp_v = exp_q.pop_front(); checks += 2;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL write_read_rs got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL write_read_rt got=%h exp=%h", ID_RT_DATA, exp_v[31:0]); end
    endtask

    task automatic test_reg_zero();
        WB_RegWrite = 1'b1; WB_RD = 5'd0; WB_DATA = 32'hFFFFFFFF;
        ID_RS = 5'd0; ID_RT = 5'd0;
        exp_q.push_back({32'h0, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks += 2;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL r0_pre_rs got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL r0_pre_rt got=%h exp=%h", ID_RT_DATA, exp_v[31:0]); end
        tick();
        WB_RegWrite = 1'b0;
        exp_q.push_back({32'h0, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL r0_post got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
    endtask

    task automatic test_we_gating();
        do_write(5'd3, 32'h0000AAAA);
        WB_RegWrite = 1'b0; WB_RD = 5'd3; WB_DATA = 32'h00005555;
        ID_RS = 5'd3; ID_RT = 5'd7;
        exp_q.push_back({32'h0000AAAA, 32'h12345678});
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL we_gate_pre got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        tick();
        exp_q.push_back({32'h0000AAAA, 32'h12345678});
        #1;
        exp_v = exp_q.pop_front(); checks += 2;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL we_gate_post got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL we_gate_other got=%h exp=%h", ID_RT_DATA, exp_v[31:0]); end
    endtask

    task automatic test_raw();
        do_write(5'd9, 32'h1);
        WB_RegWrite = 1'b1; WB_RD = 5'd9; WB_DATA = 32'h2;
        ID_RS = 5'd9; ID_RT = 5'd8;
        exp_q.push_back({(BYPASS ? 32'h2 : 32'h1), 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks += 2;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL raw_same_cycle got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL raw_other_port got=%h exp=%h", ID_RT_DATA, exp_v[31:0]); end
        tick();
        model[9] = 32'h2;
        WB_RegWrite = 1'b0;
        exp_q.push_back({32'h2, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL raw_after_edge got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
    endtask

    task automatic test_dual_port();
        do_write(5'd1, 32'h11);
        do_write(5'd31, 32'hFF);
        ID_RS = 5'd1; ID_RT = 5'd31;
        WB_RegWrite = 1'b1; WB_RD = 5'd31; WB_DATA = 32'h22;
        exp_q.push_back({32'h11, (BYPASS ? 32'h22 : 32'hFF)});
        #1;
        exp_v = exp_q.pop_front(); checks += 2;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL dual_pre_rs got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL dual_pre_rt got=%h exp=%h", ID_RT_DATA, exp_v[31:0]); end
        tick();
        model[31] = 32'h22;
        WB_RegWrite = 1'b0;
        exp_q.push_back({32'h11, 32'h22});
        #1;
        exp_v = exp_q.pop_front(); checks += 2;
        if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL dual_post_rs got=%h exp=%h", ID_RS_DATA, exp_v[63:32]); end
        if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL dual_post_rt got=%h exp=%h", ID_RT_DATA, exp_v[31:0]); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            WB_RegWrite = ($urandom_range(0, 3) != 0);
            WB_RD       = 5'($urandom_range(0, 31));
            WB_DATA     = $urandom();
            ID_RS       = ($urandom_range(0, 2) == 0) ? WB_RD : 5'($urandom_range(0, 31));
            ID_RT       = ($urandom_range(0, 2) == 0) ? WB_RD : 5'($urandom_range(0, 31));
            exp_q.push_back({ref_read(ID_RS, WB_RegWrite, WB_RD, WB_DATA, 1'b0),
                             ref_read(ID_RT, WB_RegWrite, WB_RD, WB_DATA, 1'b0)});
            #1;
            exp_v = exp_q.pop_front(); checks += 2;
            if (ID_RS_DATA !== exp_v[63:32]) begin errors++; $display("FAIL b2b_rs n=%0d idx=%0d got=%h exp=%h", n, ID_RS, ID_RS_DATA, exp_v[63:32]); end
            if (ID_RT_DATA !== exp_v[31:0]) begin errors++; $display("FAIL b2b_rt n=%0d idx=%0d got=%h exp=%h", n, ID_RT, ID_RT_DATA, exp_v[31:0]); end
            tick();
            if (WB_RegWrite && WB_RD != 5'd0) model[WB_RD] = WB_DATA;
        end
        WB_RegWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; WB_RegWrite = 1'b0; WB_DATA = 32'h0; WB_RD = 5'd0;
        ID_RS = 5'd0; ID_RT = 5'd0;
        clear_model();
        test_reset();
        test_write_read();
        test_reg_zero();
        test_we_gating();
        test_raw();
        test_dual_port();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
